seg_scan_ctrl: RTL and testbench

Four-digit 7-segment scan controller that time-multiplexes a single BCD-to-7-segment decoder across four common-anode digits. It sits directly upstream of the 4:1 digit mux and the BCD decoder: it owns the digit-select code that drives the mux select and the decoder input nibble. It also drives the active-low anode enables for the four digits. Display data is double-buffered so that a load never produces a torn frame.

---
 rtl/seg_pkg.sv | 12 +
 rtl/seg_prescaler.sv | 39 +++
 rtl/seg_scan_ctrl.sv | 112 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 7-segment display blocks.
// Contents: digit_t (BCD nibble), sel_t (digit select), AN_OFF (all anodes
// dark, active-low), NUM_DIGITS (digits per display).
package seg_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [1:0] sel_t;

  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam int         NUM_DIGITS = 4;

endpackage

// File: rtl/seg_prescaler.sv
// seg_prescaler: free-running slot counter, 0..PRESCALE-1 then wraps to 0.
// Ports: clk, rst (async, active-high); tick = last cycle of the slot;
//        lit = counter has left the GUARD blanking window (cnt >= GUARD).
module seg_prescaler #(
  parameter int PRESCALE = 100000,
  parameter int GUARD    = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic lit
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

  // A zero guard would make the compare constant-true, so it is folded away.
  if (GUARD == 0) begin : g_no_guard
    assign lit = 1'b1;
  end else begin : g_guard
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
    assign lit = (cnt >= GUARD_C);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: four-digit common-anode 7-segment scan controller with a
// double-buffered display (shadow + display buffer, swapped on the frame wrap).
// Ports: clk, rst (async, active-high); load + d0..d3 (d0 rightmost) capture
//        new digits; st = digit select, dig = BCD nibble of that digit,
//        an = active-low anodes, frame = one-cycle pulse on buffer update.
// Optional: define SEG_SCAN_LZB_EN to compile in leading-zero blanking.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int PRESCALE = 100000,
  parameter int GUARD    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [1:0] st,
  output logic [3:0] dig,
  output logic [3:0] an,
  output logic       frame
);

  logic tick;
  logic lit;
  logic wrap;

  sel_t                        sel;
  logic                        pend;
  digit_t [NUM_DIGITS-1:0]     shadow;
  digit_t [NUM_DIGITS-1:0]     disp;
  digit_t [NUM_DIGITS-1:0]     din;
  logic   [3:0]                an_nxt;
  logic   [3:0]                one_hot;

  seg_prescaler #(
    .PRESCALE (PRESCALE),
    .GUARD    (GUARD)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .lit  (lit)
  );

  assign din     = {d3, d2, d1, d0};
  assign wrap    = tick && (sel == 2'd3);
  assign one_hot = 4'b0001 << sel;

`ifdef SEG_SCAN_LZB_EN
  // lz[k]: digit k and every digit above it are zero. Digit 0 never blanks.
  logic [3:0] lz;
  always_comb begin
    lz    = 4'b0000;
    lz[3] = (disp[3] == 4'd0);
    lz[2] = lz[3] && (disp[2] == 4'd0);
    lz[1] = lz[2] && (disp[1] == 4'd0);
  end
`endif

  always_comb begin
    an_nxt = AN_OFF;
    if (lit) begin
      an_nxt = ~one_hot;
    end
`ifdef SEG_SCAN_LZB_EN
    if (lz[sel]) begin
      an_nxt = AN_OFF;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel    <= '0;
      pend   <= 1'b0;
      shadow <= '0;
      disp   <= '0;
      st     <= '0;
      dig    <= '0;
      an     <= AN_OFF;
      frame  <= 1'b0;
    end else begin
      if (tick) begin
        sel <= sel + 1'b1;
      end

      // A load on the wrap tick goes straight to the display, so nothing
      // is left pending; otherwise the wrap consumes any pending shadow.
      if (load) begin
        shadow <= din;
        pend   <= !wrap;
      end else if (wrap) begin
        pend   <= 1'b0;
      end

      if (wrap && load) begin
        disp <= din;
      end else if (wrap && pend) begin
        disp <= shadow;
      end

      frame <= wrap && (load || pend);
      st    <= sel;
      dig   <= disp[sel];
      an    <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized and directed stimulus for seg_scan_ctrl,
// checked every cycle against a time-indexed reference model.
// Ports: none (top-level bench).
module tb_seg_scan_ctrl;

  localparam int P = 4;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] d0, d1, d2, d3;
  logic [1:0] st;
  logic [3:0] dig;
  logic [3:0] an;
  logic       frame;

  int checks = 0;
  int errors = 0;

  // Reference model: position in the scan is pure arithmetic on the cycle
  // count since reset release; buffers are plain arrays.
  int         t;
  logic [3:0] m_disp   [4];
  logic [3:0] m_shadow [4];
  bit         m_pend;

  seg_scan_ctrl #(
    .PRESCALE (P),
    .GUARD    (G)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .d0    (d0),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .st    (st),
    .dig   (dig),
    .an    (an),
    .frame (frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t      = 0;
    m_pend = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_disp[k]   = 4'd0;
      m_shadow[k] = 4'd0;
    end
  endtask

  function automatic logic [3:0] exp_an(input int s, input int c);
    logic [3:0] one;
    bit         z;
    one = 4'b0001;
    if (c < G) return 4'b1111;
`ifdef SEG_SCAN_LZB_EN
    z = 1'b1;
    for (int j = s; j < 4; j++) begin
      if (m_disp[j] != 4'd0) z = 1'b0;
    end
    if (s != 0 && z) return 4'b1111;
`else
    z = 1'b0;
`endif
    return ~(one << s);
  endfunction

  // One clock: predict outputs from the pre-edge model, advance the model
  // with the inputs presented at this edge, then compare after the edge.
  task automatic step();
    int         s, c;
    bit         wrap;
    logic [3:0] dv [4];
    logic [1:0] e_st;
    logic [3:0] e_dig, e_an;
    logic       e_fr;
    s     = (t / P) % 4;
    c     = t % P;
    wrap  = (c == P - 1) && (s == 3);
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    e_st  = 2'(s);
    e_dig = m_disp[s];
    e_an  = exp_an(s, c);
    e_fr  = wrap && (load || m_pend);
    if (wrap && load) begin
      for (int k = 0; k < 4; k++) m_disp[k] = dv[k];
      m_pend = 1'b0;
    end else if (wrap && m_pend) begin
      for (int k = 0; k < 4; k++) m_disp[k] = m_shadow[k];
      m_pend = 1'b0;
    end
    if (load) begin
      for (int k = 0; k < 4; k++) m_shadow[k] = dv[k];
      m_pend = !wrap;
    end
    t++;
    @(posedge clk);
    #1;
    chk("st", 32'(st), 32'(e_st));
    chk("dig", 32'(dig), 32'(e_dig));
    chk("an", 32'(an), 32'(e_an));
    chk("frame", 32'(frame), 32'(e_fr));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Idle until the next edge to be applied has scan position (s, c).
  task automatic run_to(input int s, input int c);
    for (int i = 0; i < 4 * P + 1; i++) begin
      if (((t / P) % 4) == s && (t % P) == c) return;
      step();
    end
  endtask

  task automatic load_once(input logic [3:0] a3, input logic [3:0] a2,
                           input logic [3:0] a1, input logic [3:0] a0);
    d3 = a3; d2 = a2; d1 = a1; d0 = a0;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0;
    d0 = 4'd0; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0;
    model_reset();
    #12;
    chk("rst_st", 32'(st), 32'd0);
    chk("rst_dig", 32'(dig), 32'd0);
    chk("rst_an", 32'(an), 32'hf);
    chk("rst_frame", 32'(frame), 32'd0);
    rst = 1'b0;

    // Free scan of 1,2,3,4.
    load_once(4'd1, 4'd2, 4'd3, 4'd4);
    run(4 * P * 2);

    // Load mid-frame at sel=1.
    run_to(1, 0);
    load_once(4'd9, 4'd8, 4'd7, 4'd6);
    run(4 * P * 2);

    // Load exactly on the wrap tick.
    run_to(3, P - 1);
    load_once(4'd5, 4'd5, 4'd5, 4'd5);
    run(4 * P);

    // Two loads inside one frame; the last one wins.
    run_to(0, 1);
    load_once(4'd1, 4'd1, 4'd1, 4'd1);
    run(3);
    load_once(4'd2, 4'd2, 4'd2, 4'd2);
    run(4 * P * 2);

    // Leading-zero patterns.
    load_once(4'd0, 4'd0, 4'd0, 4'd7);
    run(4 * P * 2);
    load_once(4'd0, 4'd0, 4'd0, 4'd0);
    run(4 * P * 2);
    load_once(4'd0, 4'd0, 4'd4, 4'd2);
    run(4 * P * 2);

    // Mid-slot asynchronous reset, load captured on the release cycle.
    load_once(4'd9, 4'd3, 4'd9, 4'd3);
    run(4 * P * 2);
    run_to(2, 2);
    rst = 1'b1;
    #2;
    chk("mid_rst_st", 32'(st), 32'd0);
    chk("mid_rst_dig", 32'(dig), 32'd0);
    chk("mid_rst_an", 32'(an), 32'hf);
    chk("mid_rst_frame", 32'(frame), 32'd0);
    #4;
    rst = 1'b0;
    model_reset();
    load_once(4'd3, 4'd1, 4'd4, 4'd1);
    run(4 * P * 3);

    // Random loads and data.
    for (int i = 0; i < 1500; i++) begin
      load = ($urandom_range(0, 5) == 0);
      d0 = 4'($urandom_range(0, 15));
      d1 = 4'($urandom_range(0, 15));
      d2 = 4'($urandom_range(0, 15));
      d3 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        d2 = 4'd0; d3 = 4'd0;
      end
      step();
    end
    load = 1'b0;
    run(4 * P);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
